fetch_pipe: RTL and testbench
=============================

FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, datapath width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 Clk_Core  input  1  core clock, all state updates on rising edge.
REQ-004 Rst_Core_N  input  1  reset, asynchronous, active-low.
REQ-005 stall_di  input  1  hazard stall: hold decode-facing outputs.
REQ-006 pc_sel_di  input  1  redirect request from execute (taken branch or jump).
REQ-007 pc_target_di  input  DWIDTH  redirect target address.
REQ-008 imem_req_do  output  1  registered one-cycle instruction-memory request pulse.
REQ-009 imem_addr_do  output  DWIDTH  registered request address, valid when imem_req_do=1.
REQ-010 imem_rdata_di  input  DWIDTH  response instruction word.
REQ-011 imem_rvalid_di  input  1  response strobe, exactly one per request, 1 or more cycles after the request.
REQ-012 instruct_do / pc_do / pc_plus_do  output  DWIDTH each  registered instruction, its PC, and PC+4 to decode.
REQ-013 misalign_do  output  1  sticky misaligned-redirect flag.

Function
REQ-014 SHALL keep at most one memory request outstanding.
REQ-015 SHALL implement FSM states FE_RESET, FE_WAIT, FE_HELD, FE_DROP.
REQ-016 FE_RESET: first cycle after reset release, SHALL issue request at pc_q and go to FE_WAIT.
REQ-017 FE_WAIT, rvalid=1, stall=0, pc_sel=0: instruct_do<=rdata, pc_do<=pc_q, pc_plus_do<=pc_q+4, pc_q<=pc_q+4, issue request at pc_q+4 next cycle, remain FE_WAIT.
REQ-018 FE_WAIT, rvalid=0, stall=0: instruct_do<=32'h0000_0013 (NOP bubble), pc_do/pc_plus_do hold.
REQ-019 stall_di=1, pc_sel_di=0: instruct_do, pc_do, pc_plus_do SHALL hold; a response arriving in FE_WAIT SHALL be captured into a one-entry hold buffer with its PC, go to FE_HELD, no new request.
REQ-020 FE_HELD, stall_di=0: present buffered word/PC/PC+4, pc_q<=buffered PC+4, issue request at pc_q+4, go FE_WAIT.
REQ-021 pc_sel_di=1 SHALL have priority over stall_di in every state: pc_q<=pc_target_di, instruct_do<=NOP, hold buffer discarded.
REQ-022 Redirect in FE_WAIT with rvalid=0: go FE_DROP; next response discarded, then request issued at pc_q next cycle, go FE_WAIT.
REQ-023 Redirect in FE_WAIT with rvalid=1, in FE_HELD, or in FE_RESET: response/buffer discarded, request at target issued next cycle, go FE_WAIT.
REQ-024 A redirect during FE_DROP SHALL update pc_q only and remain FE_DROP.
REQ-025 PC arithmetic SHALL be modulo 2^DWIDTH; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-026 Asynchronous reset SHALL set state=FE_RESET, pc_q=RESET_PC, instruct_do=32'h0000_0013, pc_do=0, pc_plus_do=0, imem_req_do=0, imem_addr_do=0, misalign_do=0, hold buffer empty.
REQ-027 Reset asserted with a request outstanding SHALL abandon it; the memory is reset by the same signal.

Configuration
REQ-028 With FETCH_MISALIGN_CHK_EN defined: redirect with pc_target_di[1:0]!=0 SHALL set misalign_do (sticky until reset) and use the target with bits [1:0] forced to 0.
REQ-029 Without FETCH_MISALIGN_CHK_EN: misalign_do tied 0, target used unmodified.

Structure
REQ-030 FSM state enum, INSTR_NOP (32'h0000_0013) and PC increment (4) SHALL live in the shared core package.
REQ-031 Single module; no sub-module.

Verification
REQ-032 Reset release, memory latency 1, words A,B,C -> requests at 0,4,8; instruct_do sequence NOP,A,NOP,B,... with pc_do 0,4,8.
REQ-033 stall_di high 3 cycles while response B arrives -> outputs hold A; B presented first cycle after stall drops, pc_do=4.
REQ-034 pc_sel_di=1, target 0x100 while request outstanding -> stale response dropped, next request addr 0x100, instruct_do=NOP until 0x100 word.
REQ-035 pc_sel_di and stall_di together in FE_HELD -> buffer discarded, request 0x100 next cycle.
REQ-036 Redirect to 0xFFFF_FFFC -> pc_plus_do=0 for that instruction, next request addr 0.
REQ-037 With FETCH_MISALIGN_CHK_EN, target 0x102 -> misalign_do=1, request addr 0x100; without macro -> misalign_do=0, addr 0x102.

Source files
------------

// File: rtl/fetch_pipe_pkg.sv
// Shared core definitions for the instruction fetch stage: FSM states, the
// NOP bubble word and the sequential PC increment.
package fetch_pipe_pkg;

    typedef enum logic [1:0] {
        FE_RESET,
        FE_WAIT,
        FE_HELD,
        FE_DROP
    } fe_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_pipe_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_pipe_if #(
    parameter int DWIDTH = 32
);

    logic              imem_req_do;
    logic [DWIDTH-1:0] imem_addr_do;
    logic [DWIDTH-1:0] imem_rdata_di;
    logic              imem_rvalid_di;

    modport master (
        output imem_req_do,
        output imem_addr_do,
        input  imem_rdata_di,
        input  imem_rvalid_di
    );

    modport slave (
        input  imem_req_do,
        input  imem_addr_do,
        output imem_rdata_di,
        output imem_rvalid_di
    );

endinterface

// File: rtl/fetch_pipe.sv
// Instruction fetch stage: one outstanding imem request, stall hold buffer,
// redirect with stale-response drop. Define FETCH_MISALIGN_CHK_EN to flag and align misaligned redirect targets.
module fetch_pipe
    import fetch_pipe_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic              stall_di,
    input  logic              pc_sel_di,
    input  logic [DWIDTH-1:0] pc_target_di,
    fetch_pipe_if.master      imem,
    output logic [DWIDTH-1:0] instruct_do,
    output logic [DWIDTH-1:0] pc_do,
    output logic [DWIDTH-1:0] pc_plus_do,
    output logic              misalign_do
);

    localparam logic [DWIDTH-1:0] NOP_W = DWIDTH'(INSTR_NOP);
    localparam logic [DWIDTH-1:0] INC_W = DWIDTH'(PC_INC);

    fe_state_t         state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [DWIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [DWIDTH-1:0] instr_d, pc_do_d, pc_plus_d, addr_d;
    logic              req_d, misalign_d;
    logic [DWIDTH-1:0] target_eff;
    logic              target_bad;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target_eff = {pc_target_di[DWIDTH-1:2], 2'b00};
    assign target_bad = pc_sel_di && (pc_target_di[1:0] != 2'b00);
`else
    assign target_eff = pc_target_di;
    assign target_bad = 1'b0;
`endif

    // A redirect wins over stall; if a response is still in flight it must be swallowed first (FE_DROP).
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instruct_do;
        pc_do_d      = pc_do;
        pc_plus_d    = pc_plus_do;
        req_d        = 1'b0;
        addr_d       = imem.imem_addr_do;
        misalign_d   = misalign_do | target_bad;

        if (pc_sel_di) begin
            pc_d    = target_eff;
            instr_d = NOP_W;
            if ((state_q == FE_WAIT || state_q == FE_DROP) && !imem.imem_rvalid_di) begin
                state_d = FE_DROP;
            end else begin
                req_d   = 1'b1;
                addr_d  = target_eff;
                state_d = FE_WAIT;
            end
        end else begin
            case (state_q)
                FE_RESET: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = FE_WAIT;
                end
                FE_WAIT: begin
                    if (imem.imem_rvalid_di && stall_di) begin
                        hold_instr_d = imem.imem_rdata_di;
                        hold_pc_d    = pc_q;
                        state_d      = FE_HELD;
                    end else if (imem.imem_rvalid_di) begin
                        instr_d   = imem.imem_rdata_di;
                        pc_do_d   = pc_q;
                        pc_plus_d = pc_q + INC_W;
                        pc_d      = pc_q + INC_W;
                        req_d     = 1'b1;
                        addr_d    = pc_q + INC_W;
                    end else if (!stall_di) begin
                        instr_d = NOP_W;
                    end
                end
                FE_HELD: begin
                    if (!stall_di) begin
                        instr_d   = hold_instr_q;
                        pc_do_d   = hold_pc_q;
                        pc_plus_d = hold_pc_q + INC_W;
                        pc_d      = hold_pc_q + INC_W;
                        req_d     = 1'b1;
                        addr_d    = hold_pc_q + INC_W;
                        state_d   = FE_WAIT;
                    end
                end
                FE_DROP: begin
                    if (imem.imem_rvalid_di) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = FE_WAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q           <= FE_RESET;
            pc_q              <= RESET_PC;
            hold_instr_q      <= '0;
            hold_pc_q         <= '0;
            instruct_do       <= NOP_W;
            pc_do             <= '0;
            pc_plus_do        <= '0;
            imem.imem_req_do  <= 1'b0;
            imem.imem_addr_do <= '0;
            misalign_do       <= 1'b0;
        end else begin
            state_q           <= state_d;
            pc_q              <= pc_d;
            hold_instr_q      <= hold_instr_d;
            hold_pc_q         <= hold_pc_d;
            instruct_do       <= instr_d;
            pc_do             <= pc_do_d;
            pc_plus_do        <= pc_plus_d;
            imem.imem_req_do  <= req_d;
            imem.imem_addr_do <= addr_d;
            misalign_do       <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_pipe.sv
// Self-checking bench for fetch_pipe: transaction-level fetch model plus a
// variable-latency instruction memory, directed scenarios then random traffic.
module tb_fetch_pipe;
    import fetch_pipe_pkg::*;

    localparam int DW = 32;

    logic          Clk_Core = 1'b0;
    logic          Rst_Core_N;
    logic          stall_di;
    logic          pc_sel_di;
    logic [DW-1:0] pc_target_di;
    logic [DW-1:0] instruct_do;
    logic [DW-1:0] pc_do;
    logic [DW-1:0] pc_plus_do;
    logic          misalign_do;

    fetch_pipe_if #(.DWIDTH(DW)) imem_bus ();

    fetch_pipe #(.DWIDTH(DW), .RESET_PC(32'h0000_0000)) dut (
        .Clk_Core     (Clk_Core),
        .Rst_Core_N   (Rst_Core_N),
        .stall_di     (stall_di),
        .pc_sel_di    (pc_sel_di),
        .pc_target_di (pc_target_di),
        .imem         (imem_bus),
        .instruct_do  (instruct_do),
        .pc_do        (pc_do),
        .pc_plus_do   (pc_plus_do),
        .misalign_do  (misalign_do)
    );

    always #5 Clk_Core = ~Clk_Core;

    int tests = 0;
    int fails = 0;

    // Model view: is fetching started, is a response owed, is that response stale, is a word parked.
    bit          m_started, m_busy, m_stale, m_buf_valid, m_req, m_mis;
    logic [31:0] m_fetch, m_buf_pc, m_addr, m_instr, m_pc, m_pcplus;

    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_busy = 0; m_stale = 0; m_buf_valid = 0; m_req = 0; m_mis = 0;
        m_fetch = 32'h0; m_buf_pc = 32'h0; m_addr = 32'h0;
        m_instr = 32'h0000_0013; m_pc = 32'h0; m_pcplus = 32'h0;
    endtask

    task automatic model_issue(input logic [31:0] a);
        m_req = 1; m_addr = a; m_busy = 1; m_stale = 0;
    endtask

    task automatic model_present(input logic [31:0] pc);
        m_instr = word_at(pc); m_pc = pc; m_pcplus = pc + 32'd4;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          bad;
        bit          owed;
        bit          rv;
        rv = imem_bus.imem_rvalid_di;
`ifdef FETCH_MISALIGN_CHK_EN
        tgt = pc_target_di & 32'hFFFF_FFFC;
        bad = (pc_target_di & 32'h3) != 0;
`else
        tgt = pc_target_di;
        bad = 0;
`endif
        owed  = m_busy && !rv;
        m_req = 0;
        if (rv) m_busy = 0;
        if (pc_sel_di) begin
            m_instr = 32'h0000_0013;
            m_fetch = tgt;
            m_mis = m_mis | bad;
            m_buf_valid = 0;
            if (m_started && owed) m_stale = 1;
            else model_issue(tgt);
            m_started = 1;
        end else if (!m_started) begin
            model_issue(m_fetch);
            m_started = 1;
        end else if (rv) begin
            if (m_stale) begin
                model_issue(m_fetch);
            end else if (stall_di) begin
                m_buf_valid = 1;
                m_buf_pc = m_fetch;
            end else begin
                model_present(m_fetch);
                m_fetch = m_fetch + 32'd4;
                model_issue(m_fetch);
            end
        end else if (m_buf_valid && !stall_di) begin
            model_present(m_buf_pc);
            m_buf_valid = 0;
            m_fetch = m_buf_pc + 32'd4;
            model_issue(m_fetch);
        end else if (m_busy && !stall_di) begin
            m_instr = 32'h0000_0013;
        end
    endtask

    task automatic compare_model();
        check_output("imem_req", {31'b0, imem_bus.imem_req_do}, {31'b0, m_req});
        if (m_req) check_output("imem_addr", imem_bus.imem_addr_do, m_addr);
        check_output("instruct", instruct_do, m_instr);
        check_output("pc", pc_do, m_pc);
        check_output("pc_plus", pc_plus_do, m_pcplus);
        check_output("misalign", {31'b0, misalign_do}, {31'b0, m_mis});
    endtask

    // One clock: memory reacts, inputs are driven, model advances with the DUT edge, then compare.
    task automatic apply_stimulus(input bit stall, input bit sel, input logic [31:0] tgt, input int lat);
        imem_bus.imem_rvalid_di = 1'b0;
        imem_bus.imem_rdata_di  = $urandom;
        if (mem_pend && mem_cnt == 0) begin
            imem_bus.imem_rvalid_di = 1'b1;
            imem_bus.imem_rdata_di  = word_at(mem_addr);
            mem_pend = 0;
        end else if (mem_pend) begin
            mem_cnt--;
        end
        if (imem_bus.imem_req_do) begin
            check_output("one_outstanding", {31'b0, mem_pend}, 32'd0);
            mem_pend = 1;
            mem_addr = imem_bus.imem_addr_do;
            mem_cnt  = lat - 1;
        end
        stall_di     = stall;
        pc_sel_di    = sel;
        pc_target_di = tgt;
        @(posedge Clk_Core);
        model_step();
        #1;
        compare_model();
        @(negedge Clk_Core);
    endtask

    // Asynchronous reset applied mid-cycle; memory is reset alongside.
    task automatic do_reset();
        #3;
        Rst_Core_N = 1'b0;
        stall_di = 0; pc_sel_di = 0; pc_target_di = 0;
        imem_bus.imem_rvalid_di = 1'b0;
        mem_pend = 0;
        model_reset();
        #1;
        compare_model();
        check_output("rst_instr", instruct_do, 32'h0000_0013);
        check_output("rst_req", {31'b0, imem_bus.imem_req_do}, 32'd0);
        @(negedge Clk_Core);
        @(negedge Clk_Core);
        Rst_Core_N = 1'b1;
    endtask

    task automatic start_fetch();
        do_reset();
        repeat (3) apply_stimulus(0, 0, 32'h0, 1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] tgt;
        Rst_Core_N = 1'b0;
        stall_di = 0; pc_sel_di = 0; pc_target_di = 0;
        imem_bus.imem_rvalid_di = 1'b0;
        imem_bus.imem_rdata_di  = 32'h0;
        @(negedge Clk_Core);

        // Straight-line fetch at latency 1.
        do_reset();
        apply_stimulus(0, 0, 32'h0, 1);
        check_output("seq_req0", imem_bus.imem_addr_do, 32'h0);
        apply_stimulus(0, 0, 32'h0, 1);
        check_output("seq_nop0", instruct_do, 32'h0000_0013);
        apply_stimulus(0, 0, 32'h0, 1);
        check_output("seq_A", instruct_do, 32'hC0DE_0000);
        check_output("seq_A_pcplus", pc_plus_do, 32'h4);
        check_output("seq_req4", imem_bus.imem_addr_do, 32'h4);
        apply_stimulus(0, 0, 32'h0, 1);
        check_output("seq_nop1", instruct_do, 32'h0000_0013);
        apply_stimulus(0, 0, 32'h0, 1);
        check_output("seq_B", instruct_do, 32'hC0DE_0004);
        check_output("seq_B_pc", pc_do, 32'h4);
        check_output("seq_req8", imem_bus.imem_addr_do, 32'h8);
        repeat (2) apply_stimulus(0, 0, 32'h0, 1);
        check_output("seq_C_pc", pc_do, 32'h8);

        // Stall while B arrives.
        start_fetch();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 32'h0, 1);
            check_output("stall_hold_A", instruct_do, 32'hC0DE_0000);
        end
        apply_stimulus(0, 0, 32'h0, 1);
        check_output("stall_B", instruct_do, 32'hC0DE_0004);
        check_output("stall_B_pc", pc_do, 32'h4);
        check_output("stall_req8", imem_bus.imem_addr_do, 32'h8);

        // Redirect with a request outstanding.
        start_fetch();
        apply_stimulus(0, 1, 32'h100, 1);
        check_output("redir_nop", instruct_do, 32'h0000_0013);
        apply_stimulus(0, 0, 32'h0, 1);
        check_output("redir_req", imem_bus.imem_addr_do, 32'h100);
        check_output("redir_drop_nop", instruct_do, 32'h0000_0013);
        repeat (2) apply_stimulus(0, 0, 32'h0, 1);
        check_output("redir_word", instruct_do, 32'hC0DE_0100);

        // Redirect and stall together while a word is parked.
        start_fetch();
        repeat (2) apply_stimulus(1, 0, 32'h0, 1);
        apply_stimulus(1, 1, 32'h100, 1);
        check_output("held_redir_req", imem_bus.imem_addr_do, 32'h100);
        check_output("held_redir_nop", instruct_do, 32'h0000_0013);

        // Wrap at the top of the address space.
        start_fetch();
        apply_stimulus(0, 1, 32'hFFFF_FFFC, 1);
        repeat (3) apply_stimulus(0, 0, 32'h0, 1);
        check_output("wrap_pc", pc_do, 32'hFFFF_FFFC);
        check_output("wrap_pcplus", pc_plus_do, 32'h0);
        check_output("wrap_req", imem_bus.imem_addr_do, 32'h0);

        // Misaligned redirect target.
        start_fetch();
        apply_stimulus(0, 1, 32'h102, 1);
        apply_stimulus(0, 0, 32'h0, 1);
`ifdef FETCH_MISALIGN_CHK_EN
        check_output("mis_flag", {31'b0, misalign_do}, 32'd1);
        check_output("mis_addr", imem_bus.imem_addr_do, 32'h100);
`else
        check_output("mis_flag", {31'b0, misalign_do}, 32'd0);
        check_output("mis_addr", imem_bus.imem_addr_do, 32'h102);
`endif

        // Random traffic with variable latency and one reset mid-stream.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            r = $urandom;
            case ($urandom_range(0, 3))
                0: tgt = r & 32'hFFFF_FFFC;
                1: tgt = r;
                2: tgt = 32'hFFFF_FFFC - ($urandom_range(0, 1) * 32'd4);
                default: tgt = $urandom_range(0, 63) * 32'd4;
            endcase
            apply_stimulus($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, tgt,
                           $urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
